// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// Module      : game_pkg
// Description : Shared definitions for the level controller. This package
//               holds the game-state encodings, the default level and lives
//               limits, and a helper that sizes the hold timer.
// Revision    : 1.0 - initial release
// ============================================================================
package game_pkg;

    // Default game limits
    localparam int c_MAX_LEVEL_DEF = 8;
    localparam int c_LIVES_DEF     = 3;

    // Game-state encodings
    localparam int                   c_STATE_W      = 3;
    localparam logic [c_STATE_W-1:0] c_ST_IDLE      = 3'd0;
    localparam logic [c_STATE_W-1:0] c_ST_PLAY      = 3'd1;
    localparam logic [c_STATE_W-1:0] c_ST_HOLD_PASS = 3'd2;
    localparam logic [c_STATE_W-1:0] c_ST_HOLD_FAIL = 3'd3;
    localparam logic [c_STATE_W-1:0] c_ST_WON       = 3'd4;
    localparam logic [c_STATE_W-1:0] c_ST_OVER      = 3'd5;

    // Width of the hold counter. A count of HOLD_CYCLES-1 always fits in
    // clog2(HOLD_CYCLES) bits. The result is clamped to at least one bit so
    // that HOLD_CYCLES=1 still gives a legal vector.
    function automatic int timer_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hold_timer.sv
`default_nettype none
// ============================================================================
// Module      : hold_timer
// Description : Down-counter used for the pause between levels. Asserting
//               load presets the counter to HOLD_CYCLES-1. While count is
//               high, the counter decrements and then stops at zero. The
//               done output is high whenever the counter is zero.
// Ports       : clk   - system clock (rising edge)
//               rst   - synchronous active-high reset (clears the counter)
//               load  - preset to HOLD_CYCLES-1 (takes priority over count)
//               count - decrement enable
//               done  - counter is at zero
// Revision    : 1.0 - initial release
// ============================================================================
module hold_timer #(
    parameter int HOLD_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic count,
    output logic done
);
    import game_pkg::*;

    localparam int             c_W        = timer_width(HOLD_CYCLES);
    localparam logic [c_W-1:0] c_LOAD_VAL = c_W'(HOLD_CYCLES - 1);
    localparam logic [c_W-1:0] c_ONE      = c_W'(1);

    logic [c_W-1:0] r_count;
    logic [c_W-1:0] w_count_nx;

    always_comb begin
        w_count_nx = r_count;
        if (load) begin
            w_count_nx = c_LOAD_VAL;
        end else if (count && (r_count != '0)) begin
            w_count_nx = r_count - c_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_nx;
        end
    end

    assign done = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/level_controller.sv
`default_nettype none
// ============================================================================
// Module      : level_controller
// Description : Game level sequencer. It tracks the active level and the
//               remaining lives. After each level is passed or failed, it
//               inserts a fixed pause before the next level. It flags win
//               and game-over conditions. Every output comes from a flop.
// Ports       : clk         - system clock (rising edge)
//               rst         - synchronous active-high reset
//               start       - pulse: begin a new game (IDLE/WON/OVER only)
//               level_pass  - pulse: current level cleared
//               level_fail  - pulse: current level failed
//               curr_level  - active level 1..MAX_LEVEL, 0 in IDLE (LEDs)
//               lives_left  - remaining attempts
//               level_start - pulse in the first cycle of each level attempt
//               game_won    - high while in WON
//               game_over   - high while in OVER
// Revision    : 1.0 - initial release
// ============================================================================
module level_controller
    import game_pkg::*;
#(
    parameter int MAX_LEVEL   = c_MAX_LEVEL_DEF,
    parameter int LIVES       = c_LIVES_DEF,
    parameter int HOLD_CYCLES = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       level_pass,
    input  logic       level_fail,
    output logic [3:0] curr_level,
    output logic [2:0] lives_left,
    output logic       level_start,
    output logic       game_won,
    output logic       game_over
);

    localparam logic [3:0] c_MAX_LEVEL = 4'(MAX_LEVEL);
    localparam logic [2:0] c_LIVES     = 3'(LIVES);

    logic [c_STATE_W-1:0] r_state;
    logic [c_STATE_W-1:0] w_state_nx;
    logic [3:0]           r_curr_level;
    logic [3:0]           w_curr_level_nx;
    logic [2:0]           r_lives_left;
    logic [2:0]           w_lives_left_nx;
    logic                 r_level_start;
    logic                 w_level_start_nx;
    logic                 r_game_won;
    logic                 r_game_over;
    logic                 w_hold_load;
    logic                 w_hold_count;
    logic                 w_hold_done;

    // The timer is loaded in the same cycle the pass or fail pulse is seen.
    // The FSM then stays in the hold state until done is seen. That gives
    // HOLD_CYCLES hold cycles before the next PLAY cycle.
    hold_timer #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_hold_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (w_hold_load),
        .count (w_hold_count),
        .done  (w_hold_done)
    );

    assign w_hold_count = (r_state == c_ST_HOLD_PASS) || (r_state == c_ST_HOLD_FAIL);

    always_comb begin
        w_state_nx       = r_state;
        w_curr_level_nx  = r_curr_level;
        w_lives_left_nx  = r_lives_left;
        w_level_start_nx = 1'b0;
        w_hold_load      = 1'b0;

        case (r_state)
            c_ST_IDLE, c_ST_WON, c_ST_OVER: begin
                if (start) begin
                    w_state_nx       = c_ST_PLAY;
                    w_curr_level_nx  = 4'd1;
                    w_lives_left_nx  = c_LIVES;
                    w_level_start_nx = 1'b1;
                end
            end

            c_ST_PLAY: begin
                // A fail takes priority. A pass in the same cycle is dropped.
                if (level_fail) begin
                    if (r_lives_left > 3'd1) begin
                        w_lives_left_nx = r_lives_left - 3'd1;
                        w_state_nx      = c_ST_HOLD_FAIL;
                        w_hold_load     = 1'b1;
                    end else begin
                        w_lives_left_nx = 3'd0;
                        w_state_nx      = c_ST_OVER;
                    end
                end else if (level_pass) begin
                    if (r_curr_level < c_MAX_LEVEL) begin
                        w_state_nx  = c_ST_HOLD_PASS;
                        w_hold_load = 1'b1;
                    end else begin
                        w_state_nx = c_ST_WON;
                    end
                end
            end

            c_ST_HOLD_PASS: begin
                if (w_hold_done) begin
                    w_state_nx       = c_ST_PLAY;
                    w_level_start_nx = 1'b1;
                    if (r_curr_level < c_MAX_LEVEL) begin
                        w_curr_level_nx = r_curr_level + 4'd1;
                    end
                end
            end

            c_ST_HOLD_FAIL: begin
                if (w_hold_done) begin
                    w_state_nx       = c_ST_PLAY;
                    w_level_start_nx = 1'b1;
                end
            end

            default: begin
                w_state_nx = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_ST_IDLE;
            r_curr_level  <= 4'd0;
            r_lives_left  <= 3'd0;
            r_level_start <= 1'b0;
            r_game_won    <= 1'b0;
            r_game_over   <= 1'b0;
        end else begin
            r_state       <= w_state_nx;
            r_curr_level  <= w_curr_level_nx;
            r_lives_left  <= w_lives_left_nx;
            r_level_start <= w_level_start_nx;
            r_game_won    <= (w_state_nx == c_ST_WON);
            r_game_over   <= (w_state_nx == c_ST_OVER);
        end
    end

    assign curr_level  = r_curr_level;
    assign lives_left  = r_lives_left;
    assign level_start = r_level_start;
    assign game_won    = r_game_won;
    assign game_over   = r_game_over;

endmodule
`default_nettype wire

// File: tb/tb_level_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_level_controller
// Description : Self-checking bench for level_controller with HOLD_CYCLES=4,
//               MAX_LEVEL=8 and LIVES=3. A table of per-cycle input and
//               expected-output records runs first. Hand-written sequences
//               then cover the full climb to WON, reset during a hold, and
//               running out of lives from a fresh game.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_level_controller;

    localparam int c_HOLD = 4;

    logic       clk;
    logic       rst;
    logic       start;
    logic       level_pass;
    logic       level_fail;
    logic [3:0] curr_level;
    logic [2:0] lives_left;
    logic       level_start;
    logic       game_won;
    logic       game_over;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit         r;
        bit         s;
        bit         p;
        bit         f;
        logic [3:0] lv;
        logic [2:0] li;
        bit         ls;
        bit         w;
        bit         o;
    } vec_t;

    vec_t vq[$];

    level_controller #(
        .MAX_LEVEL   (8),
        .LIVES       (3),
        .HOLD_CYCLES (c_HOLD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .level_pass  (level_pass),
        .level_fail  (level_fail),
        .curr_level  (curr_level),
        .lives_left  (lives_left),
        .level_start (level_start),
        .game_won    (game_won),
        .game_over   (game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive inputs for one cycle, then sample 1 time unit after the edge.
    task automatic step(input bit r, input bit s, input bit p, input bit f);
        rst = r; start = s; level_pass = p; level_fail = f;
        @(posedge clk);
        #1;
        rst = 1'b0; start = 1'b0; level_pass = 1'b0; level_fail = 1'b0;
    endtask

    task automatic expect_out(input string name, input logic [3:0] lv, input logic [2:0] li,
                              input bit ls, input bit w, input bit o);
        logic [9:0] act;
        logic [9:0] exp;
        act = {curr_level, lives_left, level_start, game_won, game_over};
        exp = {lv, li, ls, w, o};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got level=%0d lives=%0d start=%b won=%b over=%b, want level=%0d lives=%0d start=%b won=%b over=%b",
                     name, curr_level, lives_left, level_start, game_won, game_over, lv, li, ls, w, o);
        end
    endtask

    task automatic add(input bit r, input bit s, input bit p, input bit f, input logic [3:0] lv,
                       input logic [2:0] li, input bit ls, input bit w, input bit o);
        vec_t v;
        v.r = r; v.s = s; v.p = p; v.f = f; v.lv = lv; v.li = li; v.ls = ls; v.w = w; v.o = o;
        vq.push_back(v);
    endtask

    // Pass level lv. Expect four hold cycles at lv, then lv+1 with a start pulse.
    task automatic pass_level(input string tag, input logic [3:0] lv, input logic [2:0] li);
        step(0, 0, 1, 0);
        expect_out($sformatf("%s_pass_l%0d_h1", tag, lv), lv, li, 0, 0, 0);
        for (int i = 2; i <= c_HOLD; i++) begin
            step(0, 0, 0, 0);
            expect_out($sformatf("%s_pass_l%0d_h%0d", tag, lv, i), lv, li, 0, 0, 0);
        end
        step(0, 0, 0, 0);
        expect_out($sformatf("%s_pass_l%0d_next", tag, lv), lv + 4'd1, li, 1, 0, 0);
    endtask

    // Fail with lives li > 1. Expect four hold cycles with li-1, then a restart of the same level.
    task automatic fail_level(input string tag, input logic [3:0] lv, input logic [2:0] li);
        step(0, 0, 0, 1);
        expect_out($sformatf("%s_fail_l%0d_h1", tag, lv), lv, li - 3'd1, 0, 0, 0);
        for (int i = 2; i <= c_HOLD; i++) begin
            step(0, 0, 0, 0);
            expect_out($sformatf("%s_fail_l%0d_h%0d", tag, lv, i), lv, li - 3'd1, 0, 0, 0);
        end
        step(0, 0, 0, 0);
        expect_out($sformatf("%s_fail_l%0d_retry", tag, lv), lv, li - 3'd1, 1, 0, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0; start = 1'b0; level_pass = 1'b0; level_fail = 1'b0;

        //   r  s  p  f   lvl  lives ls w  o
        add(1, 0, 0, 0, 4'd0, 3'd0, 0, 0, 0);   // reset
        add(0, 0, 0, 0, 4'd0, 3'd0, 0, 0, 0);   // idle
        add(0, 1, 0, 0, 4'd1, 3'd3, 1, 0, 0);   // start -> level 1
        add(0, 0, 0, 0, 4'd1, 3'd3, 0, 0, 0);   // level_start is one cycle only
        add(0, 0, 1, 0, 4'd1, 3'd3, 0, 0, 0);   // pass -> hold 1
        add(0, 1, 0, 0, 4'd1, 3'd3, 0, 0, 0);   // start ignored in hold
        add(0, 0, 0, 1, 4'd1, 3'd3, 0, 0, 0);   // fail ignored in hold
        add(0, 0, 0, 0, 4'd1, 3'd3, 0, 0, 0);   // hold 4
        add(0, 0, 0, 0, 4'd2, 3'd3, 1, 0, 0);   // level 2
        add(0, 0, 1, 1, 4'd2, 3'd2, 0, 0, 0);   // pass+fail: fail wins
        add(0, 0, 0, 0, 4'd2, 3'd2, 0, 0, 0);
        add(0, 0, 0, 0, 4'd2, 3'd2, 0, 0, 0);
        add(0, 0, 0, 0, 4'd2, 3'd2, 0, 0, 0);
        add(0, 0, 0, 0, 4'd2, 3'd2, 1, 0, 0);   // retry level 2
        add(0, 1, 0, 0, 4'd2, 3'd2, 0, 0, 0);   // start ignored in PLAY
        add(0, 0, 1, 0, 4'd2, 3'd2, 0, 0, 0);
        add(0, 0, 0, 0, 4'd2, 3'd2, 0, 0, 0);
        add(0, 0, 0, 0, 4'd2, 3'd2, 0, 0, 0);
        add(0, 0, 0, 0, 4'd2, 3'd2, 0, 0, 0);
        add(0, 0, 0, 0, 4'd3, 3'd2, 1, 0, 0);   // level 3
        add(0, 0, 0, 1, 4'd3, 3'd1, 0, 0, 0);
        add(0, 0, 0, 0, 4'd3, 3'd1, 0, 0, 0);
        add(0, 0, 0, 0, 4'd3, 3'd1, 0, 0, 0);
        add(0, 0, 0, 0, 4'd3, 3'd1, 0, 0, 0);
        add(0, 0, 0, 0, 4'd3, 3'd1, 1, 0, 0);
        add(0, 0, 0, 1, 4'd3, 3'd0, 0, 0, 1);   // last life -> OVER
        add(0, 0, 1, 0, 4'd3, 3'd0, 0, 0, 1);   // pass ignored in OVER
        add(0, 0, 0, 1, 4'd3, 3'd0, 0, 0, 1);   // fail ignored, no underflow
        add(0, 1, 0, 0, 4'd1, 3'd3, 1, 0, 0);   // start from OVER -> fresh game
        add(1, 1, 0, 0, 4'd0, 3'd0, 0, 0, 0);   // reset beats start

        foreach (vq[i]) begin
            step(vq[i].r, vq[i].s, vq[i].p, vq[i].f);
            expect_out($sformatf("vec%0d", i), vq[i].lv, vq[i].li, vq[i].ls, vq[i].w, vq[i].o);
        end

        // Climb all eight levels to WON.
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        expect_out("win_start", 4'd1, 3'd3, 1, 0, 0);
        for (int l = 1; l < 8; l++) pass_level("win", 4'(l), 3'd3);
        step(0, 0, 1, 0);
        expect_out("win_enter", 4'd8, 3'd3, 0, 1, 0);
        step(0, 0, 1, 0);
        expect_out("win_extra_pass", 4'd8, 3'd3, 0, 1, 0);
        step(0, 0, 0, 1);
        expect_out("win_fail_ignored", 4'd8, 3'd3, 0, 1, 0);
        step(0, 0, 0, 0);
        expect_out("win_hold", 4'd8, 3'd3, 0, 1, 0);
        step(0, 1, 0, 0);
        expect_out("win_restart", 4'd1, 3'd3, 1, 0, 0);

        // Reset during HOLD_PASS at level 5.
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        for (int l = 1; l < 5; l++) pass_level("rst", 4'(l), 3'd3);
        step(0, 0, 1, 0);
        expect_out("rst_hold_l5", 4'd5, 3'd3, 0, 0, 0);
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        expect_out("rst_in_hold", 4'd0, 3'd0, 0, 0, 0);
        step(0, 0, 0, 0);
        expect_out("rst_idle_a", 4'd0, 3'd0, 0, 0, 0);
        step(0, 0, 0, 0);
        expect_out("rst_idle_b", 4'd0, 3'd0, 0, 0, 0);
        step(0, 1, 0, 0);
        expect_out("rst_restart", 4'd1, 3'd3, 1, 0, 0);

        // Three fails at level 3 from a fresh game.
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        pass_level("over", 4'd1, 3'd3);
        pass_level("over", 4'd2, 3'd3);
        fail_level("over", 4'd3, 3'd3);
        fail_level("over", 4'd3, 3'd2);
        step(0, 0, 0, 1);
        expect_out("over_enter", 4'd3, 3'd0, 0, 0, 1);
        step(0, 0, 0, 0);
        expect_out("over_hold", 4'd3, 3'd0, 0, 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/level_controller.md
LEVEL_CONTROLLER -- requirements
Module: level_controller

Interface
REQ-001 Parameter MAX_LEVEL, default 8: highest level; legal range 1..15.
REQ-002 Parameter LIVES, default 3: attempts before game over; legal range 1..7.
REQ-003 Parameter HOLD_CYCLES, default 50000000: cycles spent in the inter-level hold; minimum 1.
REQ-004 clk  input  1  single system clock; all logic on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle pulse that begins a game.
REQ-007 level_pass  input  1  one-cycle pulse: current level cleared.
REQ-008 level_fail  input  1  one-cycle pulse: current level failed.
REQ-009 curr_level  output  4  active level, 1..MAX_LEVEL; 0 only in IDLE; drives the LED display.
REQ-010 lives_left  output  3  remaining attempts.
REQ-011 level_start  output  1  one-cycle pulse each time a level is entered or re-entered.
REQ-012 game_won  output  1  level high while in WON.
REQ-013 game_over  output  1  level high while in OVER.

Function
REQ-014 The FSM SHALL have five states: IDLE, PLAY, HOLD_PASS, HOLD_FAIL, WON and OVER.
- Correction to REQ-014: there are six states, as listed.
REQ-015 IDLE: on start, go to PLAY next cycle; set curr_level=1 and lives_left=LIVES; pulse level_start in the first PLAY cycle.
REQ-016 PLAY, level_pass with curr_level<MAX_LEVEL: go to HOLD_PASS and load hold counter with HOLD_CYCLES-1.
REQ-017 PLAY, level_pass with curr_level==MAX_LEVEL: go to WON; curr_level holds MAX_LEVEL.
REQ-018 PLAY, level_fail with lives_left>1: decrement lives_left; go to HOLD_FAIL; load hold counter.
REQ-019 PLAY, level_fail with lives_left==1: lives_left becomes 0; go to OVER.
REQ-020 level_pass and level_fail in the same PLAY cycle: fail takes priority; pass is discarded.
REQ-021 HOLD_PASS: counter decrements each cycle; at 0, increment curr_level, return to PLAY, and pulse level_start in that PLAY cycle.
REQ-022 HOLD_FAIL: counter decrements each cycle; at 0, return to PLAY with curr_level unchanged and pulse level_start.
REQ-023 Hold duration SHALL be exactly HOLD_CYCLES cycles from the cycle after the pass/fail pulse to the first PLAY cycle.
REQ-024 level_pass, level_fail and start SHALL be ignored in HOLD_PASS and HOLD_FAIL.
REQ-025 WON and OVER: outputs hold; start returns to PLAY with a fresh game (as REQ-015); level_pass and level_fail are ignored.
REQ-026 start in PLAY or a hold state SHALL be ignored.
REQ-027 curr_level SHALL never exceed MAX_LEVEL or wrap; lives_left SHALL never underflow.
REQ-028 All outputs SHALL be registered; there is no combinational input-to-output path.

Reset
REQ-029 rst SHALL take priority over all inputs: state=IDLE, curr_level=0, lives_left=0, hold counter=0, level_start=0, game_won=0, game_over=0 on the next edge.
REQ-030 Reset during a hold or mid-game SHALL abandon the game; there is no retained progress.

Structure
REQ-031 State encodings and the MAX_LEVEL/LIVES defaults SHALL live in a shared package, game_pkg.
REQ-032 The hold counter SHALL be a sub-module, hold_timer, with inputs load and count and output done; width is clog2(HOLD_CYCLES).
REQ-033 curr_level SHALL connect directly to the existing LED display block.

Verification (HOLD_CYCLES=4, MAX_LEVEL=8, LIVES=3)
REQ-034 Assert rst, then start -> curr_level 0 to 1, lives_left=3, level_start high for exactly 1 cycle.
REQ-035 level_pass at level 1 -> curr_level stays 1 for 4 cycles, then 2, with a level_start pulse in the same cycle.
REQ-036 Eight passes, each after its hold -> curr_level=8 then game_won=1; further passes leave curr_level=8.
REQ-037 Three fails at level 3 -> lives_left goes 2, 1, then 0 with game_over=1; curr_level stays 3.
REQ-038 level_pass and level_fail in the same cycle at level 2, lives 3 -> lives_left=2, curr_level=2 after the hold.
REQ-039 rst during HOLD_PASS at level 5 -> next cycle IDLE with all outputs 0; a later start restarts at level 1.
